pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage CPU, used between EX/MEM and MEM/WB. It carries NUM_CH data words plus PC, packed control, register-write request and the forwarding age counter Tnew. Unlike a plain clocked latch, it supports stall (hold), flush (bubble insertion), $0 write suppression, and Tnew ageing while held. It also keeps a saturating count of held-valid cycles for hazard diagnostics.

## Interface
- NUM_CH, 3, number of data channels (ALU result, read data, PC+8 …)
- DATA_W, 32, width of each data channel and of PC
- CTRL_W, 2, width of packed control field (e.g. write-data select)
- WA_W, 5, register address width
- TNEW_W, 2, Tnew width
- TNEW_DEC, 1, 1 = Tnew decrements per cycle; 0 = Tnew passes through unchanged
- HCNT_W, 16, hold-counter width
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-low (reset==0 resets on the rising clk edge)
- en  in  1  advance: capture inputs this edge; 0 = hold
- flush  in  1  load a bubble this edge
- data_in  in  NUM_CH*DATA_W  channel k at bits [k*DATA_W +: DATA_W]
- pc_in  in  DATA_W  instruction PC
- ctrl_in  in  CTRL_W  packed control
- we_in  in  1  register-file write request
- wa_in  in  WA_W  write address
- tnew_in  in  TNEW_W  cycles until result ready, as seen by the upstream stage
- valid_in  in  1  upstream slot holds a real instruction
- data_out, pc_out, ctrl_out, wa_out, tnew_out  out  same widths  registered fields
- we_out, valid_out  out  1  registered
- hold_cnt  out  HCNT_W  consecutive held-valid cycles

## Operation
- Priority per edge: reset > flush > en > hold.
- Reset (reset==0): every output is 0, including hold_cnt.
- Flush (reset==1, flush==1, regardless of en):
  - data_out, ctrl_out, we_out, wa_out, tnew_out, valid_out and hold_cnt load 0.
  - pc_out loads pc_in, so the bubble keeps its PC for debug/exception reporting.
- Advance (en==1, no flush):
  - data_out, pc_out, ctrl_out and valid_out load their inputs.
  - Write request: if valid_in & we_in & (wa_in != 0), we_out=1 and wa_out=wa_in. Otherwise we_out=0 and wa_out=0. This stops false forwarding from $0 or invalid slots.
  - tnew_out = TNEW_DEC ? satdec(tnew_in) : tnew_in, where satdec(x) = (x==0) ? 0 : x-1 at TNEW_W bits. Never wraps.
  - hold_cnt clears to 0.
- Hold (en==0, no flush):
  - All fields keep their values.
  - tnew_out = TNEW_DEC ? satdec(tnew_out) : tnew_out. The held instruction ages.
  - hold_cnt increments if valid_out==1, saturating at all-ones. If valid_out==0 it stays unchanged.
- The block has no combinational path from inputs to outputs.

## Timing
- Latency 1 cycle: inputs sampled at edge N appear on outputs after edge N, stable for all of cycle N+1.
- Hold may last arbitrarily long. Outputs are constant except tnew_out (counts down to 0 and sticks) and hold_cnt (counts up to 2^HCNT_W-1 and sticks).
- Flush and en high together: flush wins and the inputs are discarded.
- Reset low mid-hold or mid-flush: reset wins at that edge. Normal operation resumes at the first edge with reset==1.
- tnew_in = 0 on advance gives tnew_out = 0 (no underflow).
- The all-ones value of tnew_in reaches 0 after TNEW_W-dependent steps: 2^TNEW_W-1 decrements in total, counting the advance edge.

## Test plan
- Reset: drive reset=0 for one edge with random inputs -> all outputs 0. Then reset=1, en=1, valid_in=1, we_in=1, wa_in=5, tnew_in=2, pc_in=0x3000 -> next cycle we_out=1, wa_out=5, tnew_out=1, pc_out=0x3000, valid_out=1.
- Hold ageing (TNEW_DEC=1): advance with tnew_in=3, then en=0 for 4 edges -> tnew_out sequence 2,1,0,0,0. Data and pc held. hold_cnt sequence 0,1,2,3,4.
- Flush priority: en=1, flush=1, pc_in=0x3010, we_in=1, wa_in=7 -> valid_out=0, we_out=0, wa_out=0, tnew_out=0, pc_out=0x3010, hold_cnt=0.
- $0 suppression: advance with we_in=1, wa_in=0, valid_in=1 -> we_out=0, wa_out=0. Advance with we_in=1, wa_in=9, valid_in=0 -> we_out=0, wa_out=0.
- Counter saturation (HCNT_W=2): load a valid slot, hold 6 edges -> hold_cnt 1,2,3,3,3,3. One advance -> 0. Hold with valid_out=0 -> hold_cnt stays 0.
- Pass-through mode (TNEW_DEC=0, NUM_CH=2): tnew_in=2 advanced then held 3 edges -> tnew_out stays 2. data_in={0xDEADBEEF,0x12345678} -> data_out identical, channel 0 at the low bits.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - inter-stage pipeline register with stall, flush, $0 write suppression and Tnew ageing
//
// Purpose: holds one instruction slot between two CPU pipeline stages. It carries
//   NUM_CH data words, PC, packed control, a register-write request and the
//   forwarding age counter Tnew. A saturating counter reports how many
//   consecutive cycles a valid slot has been held.
// Ports:
//   clk                      rising-edge clock
//   reset                    synchronous, active-low
//   en                       1 = capture inputs, 0 = hold
//   flush                    load a bubble (wins over en)
//   data_in / data_out       NUM_CH*DATA_W, channel k at [k*DATA_W +: DATA_W]
//   pc_in / pc_out           instruction PC (kept through a flush)
//   ctrl_in / ctrl_out       packed control
//   we_in, wa_in / we_out, wa_out   register-file write request and address
//   tnew_in / tnew_out       cycles until the result is ready
//   valid_in / valid_out     slot holds a real instruction
//   hold_cnt                 consecutive held-valid cycles, saturating
module pipe_stage_reg #(
    parameter int NUM_CH   = 3,
    parameter int DATA_W   = 32,
    parameter int CTRL_W   = 2,
    parameter int WA_W     = 5,
    parameter int TNEW_W   = 2,
    parameter int TNEW_DEC = 1,
    parameter int HCNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     flush,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0]        pc_in,
    input  logic [CTRL_W-1:0]        ctrl_in,
    input  logic                     we_in,
    input  logic [WA_W-1:0]          wa_in,
    input  logic [TNEW_W-1:0]        tnew_in,
    input  logic                     valid_in,
    output logic [NUM_CH*DATA_W-1:0] data_out,
    output logic [DATA_W-1:0]        pc_out,
    output logic [CTRL_W-1:0]        ctrl_out,
    output logic                     we_out,
    output logic [WA_W-1:0]          wa_out,
    output logic [TNEW_W-1:0]        tnew_out,
    output logic                     valid_out,
    output logic [HCNT_W-1:0]        hold_cnt
);

    logic [NUM_CH*DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0]        pc_q, pc_d;
    logic [CTRL_W-1:0]        ctrl_q, ctrl_d;
    logic                     we_q, we_d;
    logic [WA_W-1:0]          wa_q, wa_d;
    logic [TNEW_W-1:0]        tnew_q, tnew_d;
    logic                     valid_q, valid_d;
    logic [HCNT_W-1:0]        hcnt_q, hcnt_d;

    // Tnew ages by one per cycle when enabled; it sticks at zero rather than wrapping.
    function automatic logic [TNEW_W-1:0] age(input logic [TNEW_W-1:0] x);
        if (TNEW_DEC == 0)
            return x;
        else if (x == '0)
            return '0;
        else
            return x - TNEW_W'(1);
    endfunction

    always_comb begin
        data_d  = data_q;
        pc_d    = pc_q;
        ctrl_d  = ctrl_q;
        we_d    = we_q;
        wa_d    = wa_q;
        tnew_d  = tnew_q;
        valid_d = valid_q;
        hcnt_d  = hcnt_q;
        if (flush) begin
            // Bubble keeps its PC so exceptions/debug can still name the slot.
            data_d  = '0;
            pc_d    = pc_in;
            ctrl_d  = '0;
            we_d    = 1'b0;
            wa_d    = '0;
            tnew_d  = '0;
            valid_d = 1'b0;
            hcnt_d  = '0;
        end else if (en) begin
            data_d  = data_in;
            pc_d    = pc_in;
            ctrl_d  = ctrl_in;
            valid_d = valid_in;
            // Writes to $0 or from an empty slot must never be seen by forwarding.
            if (valid_in && we_in && (wa_in != '0)) begin
                we_d = 1'b1;
                wa_d = wa_in;
            end else begin
                we_d = 1'b0;
                wa_d = '0;
            end
            tnew_d  = age(tnew_in);
            hcnt_d  = '0;
        end else begin
            tnew_d = age(tnew_q);
            if (valid_q && (hcnt_q != '1))
                hcnt_d = hcnt_q + HCNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q  <= '0;
            pc_q    <= '0;
            ctrl_q  <= '0;
            we_q    <= 1'b0;
            wa_q    <= '0;
            tnew_q  <= '0;
            valid_q <= 1'b0;
            hcnt_q  <= '0;
        end else begin
            data_q  <= data_d;
            pc_q    <= pc_d;
            ctrl_q  <= ctrl_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            tnew_q  <= tnew_d;
            valid_q <= valid_d;
            hcnt_q  <= hcnt_d;
        end
    end

    assign data_out  = data_q;
    assign pc_out    = pc_q;
    assign ctrl_out  = ctrl_q;
    assign we_out    = we_q;
    assign wa_out    = wa_q;
    assign tnew_out  = tnew_q;
    assign valid_out = valid_q;
    assign hold_cnt  = hcnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg (default, HCNT_W=2, pass-through variants)
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset, en, flush, we_in, valid_in;
    logic [95:0] data_in;
    logic [31:0] pc_in;
    logic [1:0]  ctrl_in;
    logic [4:0]  wa_in;
    logic [1:0]  tnew_in;

    int checks = 0;
    int failures = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    // Instance A: default parameters
    logic [95:0] a_data; logic [31:0] a_pc; logic [1:0] a_ctrl; logic a_we; logic [4:0] a_wa;
    logic [1:0]  a_tnew; logic a_valid; logic [15:0] a_hcnt;
    // Instance B: tiny hold counter
    logic [95:0] b_data; logic [31:0] b_pc; logic [1:0] b_ctrl; logic b_we; logic [4:0] b_wa;
    logic [1:0]  b_tnew; logic b_valid; logic [1:0] b_hcnt;
    // Instance C: two channels, Tnew passes through
    logic [63:0] c_data; logic [31:0] c_pc; logic [1:0] c_ctrl; logic c_we; logic [4:0] c_wa;
    logic [1:0]  c_tnew; logic c_valid; logic [15:0] c_hcnt;

    pipe_stage_reg u_a (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .data_in(data_in), .pc_in(pc_in),
        .ctrl_in(ctrl_in), .we_in(we_in), .wa_in(wa_in), .tnew_in(tnew_in), .valid_in(valid_in),
        .data_out(a_data), .pc_out(a_pc), .ctrl_out(a_ctrl), .we_out(a_we), .wa_out(a_wa),
        .tnew_out(a_tnew), .valid_out(a_valid), .hold_cnt(a_hcnt)
    );

    pipe_stage_reg #(.HCNT_W(2)) u_b (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .data_in(data_in), .pc_in(pc_in),
        .ctrl_in(ctrl_in), .we_in(we_in), .wa_in(wa_in), .tnew_in(tnew_in), .valid_in(valid_in),
        .data_out(b_data), .pc_out(b_pc), .ctrl_out(b_ctrl), .we_out(b_we), .wa_out(b_wa),
        .tnew_out(b_tnew), .valid_out(b_valid), .hold_cnt(b_hcnt)
    );

    pipe_stage_reg #(.NUM_CH(2), .TNEW_DEC(0)) u_c (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .data_in(data_in[63:0]), .pc_in(pc_in),
        .ctrl_in(ctrl_in), .we_in(we_in), .wa_in(wa_in), .tnew_in(tnew_in), .valid_in(valid_in),
        .data_out(c_data), .pc_out(c_pc), .ctrl_out(c_ctrl), .we_out(c_we), .wa_out(c_wa),
        .tnew_out(c_tnew), .valid_out(c_valid), .hold_cnt(c_hcnt)
    );

    // Reference model: what the slot must contain, from the operational rules.
    typedef struct {
        logic [95:0] data;
        logic [31:0] pc;
        logic [1:0]  ctrl;
        logic        we;
        logic [4:0]  wa;
        int          tnew;
        logic        valid;
        int          hcnt;
    } mstate_t;

    mstate_t ma, mb, mc;

    function automatic mstate_t step(mstate_t s, bit tdec, int hmax, logic [95:0] mask);
        mstate_t n;
        n = s;
        if (!reset) begin
            n.data = '0; n.pc = '0; n.ctrl = '0; n.we = 0; n.wa = '0;
            n.tnew = 0; n.valid = 0; n.hcnt = 0;
        end else if (flush) begin
            n.data = '0; n.pc = pc_in; n.ctrl = '0; n.we = 0; n.wa = '0;
            n.tnew = 0; n.valid = 0; n.hcnt = 0;
        end else if (en) begin
            n.data  = data_in & mask;
            n.pc    = pc_in;
            n.ctrl  = ctrl_in;
            n.valid = valid_in;
            n.we    = valid_in && we_in && (wa_in != 0);
            n.wa    = n.we ? wa_in : 5'd0;
            n.tnew  = tdec ? ((int'(tnew_in) > 0) ? int'(tnew_in) - 1 : 0) : int'(tnew_in);
            n.hcnt  = 0;
        end else begin
            if (tdec && s.tnew > 0) n.tnew = s.tnew - 1;
            if (s.valid && s.hcnt < hmax) n.hcnt = s.hcnt + 1;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        ma <= step(ma, 1'b1, 65535, {96{1'b1}});
        mb <= step(mb, 1'b1, 3, {96{1'b1}});
        mc <= step(mc, 1'b0, 65535, {32'h0, {64{1'b1}}});
        started <= 1'b1;
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("a.data", a_data, ma.data);
            chk("a.pc", 96'(a_pc), 96'(ma.pc));
            chk("a.ctrl", 96'(a_ctrl), 96'(ma.ctrl));
            chk("a.we", 96'(a_we), 96'(ma.we));
            chk("a.wa", 96'(a_wa), 96'(ma.wa));
            chk("a.tnew", 96'(a_tnew), 96'(ma.tnew));
            chk("a.valid", 96'(a_valid), 96'(ma.valid));
            chk("a.hcnt", 96'(a_hcnt), 96'(ma.hcnt));
            chk("b.tnew", 96'(b_tnew), 96'(mb.tnew));
            chk("b.we", 96'(b_we), 96'(mb.we));
            chk("b.hcnt", 96'(b_hcnt), 96'(mb.hcnt));
            chk("c.data", 96'(c_data), mc.data);
            chk("c.pc", 96'(c_pc), 96'(mc.pc));
            chk("c.wa", 96'(c_wa), 96'(mc.wa));
            chk("c.tnew", 96'(c_tnew), 96'(mc.tnew));
            chk("c.valid", 96'(c_valid), 96'(mc.valid));
            chk("c.hcnt", 96'(c_hcnt), 96'(mc.hcnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    initial begin
        int tn_exp[4];
        int sat_exp[6];
        tn_exp  = '{1, 0, 0, 0};
        sat_exp = '{1, 2, 3, 3, 3, 3};

        // Reset with arbitrary inputs
        reset = 1'b0; en = 1'b1; flush = 1'b0;
        data_in = {$urandom, $urandom, $urandom}; pc_in = $urandom; ctrl_in = 2'd3;
        we_in = 1'b1; wa_in = 5'd17; tnew_in = 2'd3; valid_in = 1'b1;
        tick();
        chk("rst.valid", 96'(a_valid), 96'd0);
        chk("rst.we", 96'(a_we), 96'd0);
        chk("rst.pc", 96'(a_pc), 96'd0);
        chk("rst.data", a_data, 96'd0);
        chk("rst.tnew", 96'(a_tnew), 96'd0);
        chk("rst.hcnt", 96'(a_hcnt), 96'd0);

        // First advance after reset
        reset = 1'b1; wa_in = 5'd5; tnew_in = 2'd2; pc_in = 32'h3000; ctrl_in = 2'd1;
        data_in = 96'h111111112222222233333333;
        tick();
        chk("adv.we", 96'(a_we), 96'd1);
        chk("adv.wa", 96'(a_wa), 96'd5);
        chk("adv.tnew", 96'(a_tnew), 96'd1);
        chk("adv.pc", 96'(a_pc), 96'h3000);
        chk("adv.valid", 96'(a_valid), 96'd1);

        // Hold ageing
        tnew_in = 2'd3; pc_in = 32'h3004; data_in = 96'hAAAA0000BBBB1111CCCC2222;
        tick();
        chk("age.tnew0", 96'(a_tnew), 96'd2);
        chk("age.hcnt0", 96'(a_hcnt), 96'd0);
        en = 1'b0; pc_in = 32'h9999; data_in = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("age.tnew", 96'(a_tnew), 96'(tn_exp[i]));
            chk("age.hcnt", 96'(a_hcnt), 96'(i + 1));
            chk("age.pc", 96'(a_pc), 96'h3004);
            chk("age.data", a_data, 96'hAAAA0000BBBB1111CCCC2222);
            chk("age.bhcnt", 96'(b_hcnt), 96'(sat_exp[i]));
        end

        // Flush beats en
        en = 1'b1; flush = 1'b1; pc_in = 32'h3010; we_in = 1'b1; wa_in = 5'd7; valid_in = 1'b1;
        tick();
        chk("fl.valid", 96'(a_valid), 96'd0);
        chk("fl.we", 96'(a_we), 96'd0);
        chk("fl.wa", 96'(a_wa), 96'd0);
        chk("fl.tnew", 96'(a_tnew), 96'd0);
        chk("fl.pc", 96'(a_pc), 96'h3010);
        chk("fl.hcnt", 96'(a_hcnt), 96'd0);
        flush = 1'b0; en = 1'b0;
        tick();
        tick();
        chk("fl.hold.hcnt", 96'(a_hcnt), 96'd0);
        chk("fl.hold.bhcnt", 96'(b_hcnt), 96'd0);

        // $0 and invalid-slot write suppression
        en = 1'b1; valid_in = 1'b1; we_in = 1'b1; wa_in = 5'd0;
        tick();
        chk("z0.we", 96'(a_we), 96'd0);
        chk("z0.wa", 96'(a_wa), 96'd0);
        valid_in = 1'b0; wa_in = 5'd9;
        tick();
        chk("inv.we", 96'(a_we), 96'd0);
        chk("inv.wa", 96'(a_wa), 96'd0);

        // Hold counter saturation on the 2-bit instance
        valid_in = 1'b1; wa_in = 5'd3;
        tick();
        en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("sat.bhcnt", 96'(b_hcnt), 96'(sat_exp[i]));
        end
        en = 1'b1;
        tick();
        chk("sat.clr", 96'(b_hcnt), 96'd0);
        valid_in = 1'b0;
        tick();
        en = 1'b0;
        tick();
        tick();
        chk("sat.inv", 96'(b_hcnt), 96'd0);

        // Pass-through Tnew, two channels
        en = 1'b1; valid_in = 1'b1; tnew_in = 2'd2;
        data_in = {32'h0, 32'hDEADBEEF, 32'h12345678};
        tick();
        chk("pt.data", 96'(c_data), 96'hDEADBEEF12345678);
        chk("pt.ch0", 96'(c_data[31:0]), 96'h12345678);
        chk("pt.tnew", 96'(c_tnew), 96'd2);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pt.hold.tnew", 96'(c_tnew), 96'd2);
        end

        // tnew_in = 0 does not underflow
        en = 1'b1; tnew_in = 2'd0;
        tick();
        chk("tn0", 96'(a_tnew), 96'd0);

        // Reset wins mid-hold and over flush
        tnew_in = 2'd3; pc_in = 32'h4000;
        tick();
        en = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("rh.valid", 96'(a_valid), 96'd0);
        chk("rh.hcnt", 96'(a_hcnt), 96'd0);
        chk("rh.pc", 96'(a_pc), 96'd0);
        flush = 1'b1;
        tick();
        chk("rf.pc", 96'(a_pc), 96'd0);
        reset = 1'b1; flush = 1'b0; en = 1'b1; pc_in = 32'h4008;
        tick();
        chk("rr.valid", 96'(a_valid), 96'd1);
        chk("rr.pc", 96'(a_pc), 96'h4008);

        // Random traffic, checked by the model every cycle
        for (int i = 0; i < 60; i++) begin
            reset    = ($urandom_range(0, 15) != 0);
            flush    = ($urandom_range(0, 5) == 0);
            en       = ($urandom_range(0, 2) != 0);
            data_in  = {$urandom, $urandom, $urandom};
            pc_in    = $urandom;
            ctrl_in  = 2'($urandom);
            we_in    = 1'($urandom);
            wa_in    = 5'($urandom_range(0, 3));
            tnew_in  = 2'($urandom);
            valid_in = 1'($urandom);
            tick();
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
